// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART core: independent TX and RX frame engines sharing one clock,
// with mid-bit RX sampling and per-frame parity/framing error reporting.
module uart_core_param #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_din,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_dout,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY_ODD != 0) ? ~(^d) : (^d);
    endfunction

    state_t                 tx_state_r, tx_state_s;
    logic [CW-1:0]          tx_cnt_r, tx_cnt_s;
    logic [IW-1:0]          tx_idx_r, tx_idx_s;
    logic                   tx_stop_r, tx_stop_s;
    logic [DATA_BITS-1:0]   tx_shift_r, tx_shift_s;
    logic                   tx_par_r, tx_par_s;
    logic                   tx_r, tx_s;
    logic                   tx_busy_r, tx_busy_s;
    logic                   tx_done_r, tx_done_s;

    state_t                 rx_state_r, rx_state_s;
    logic [CW-1:0]          rx_cnt_r, rx_cnt_s;
    logic [IW-1:0]          rx_idx_r, rx_idx_s;
    logic [DATA_BITS-1:0]   rx_shift_r, rx_shift_s;
    logic                   rx_perr_r, rx_perr_s;
    logic                   rx_meta_r, rx_sync_r, rx_prev_r;
    logic [DATA_BITS-1:0]   rx_dout_r, rx_dout_s;
    logic                   rx_valid_r, rx_valid_s;
    logic                   rx_perr_out_r, rx_perr_out_s;
    logic                   rx_ferr_r, rx_ferr_s;

    assign tx            = tx_r;
    assign tx_busy       = tx_busy_r;
    assign tx_done       = tx_done_r;
    assign rx_dout       = rx_dout_r;
    assign rx_valid      = rx_valid_r;
    assign rx_parity_err = rx_perr_out_r;
    assign rx_frame_err  = rx_ferr_r;

    // TX next-state: the line value is computed one cycle ahead so tx leaves a flop
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r;
        tx_idx_s   = tx_idx_r;
        tx_stop_s  = tx_stop_r;
        tx_shift_s = tx_shift_r;
        tx_par_s   = tx_par_r;
        tx_s       = tx_r;
        tx_busy_s  = tx_busy_r;
        tx_done_s  = 1'b0;
        case (tx_state_r)
            ST_IDLE: begin
                tx_s      = 1'b1;
                tx_busy_s = 1'b0;
                if (tx_start && !tx_busy_r) begin
                    tx_shift_s = tx_din;
                    tx_par_s   = parity_of(tx_din);
                    tx_cnt_s   = '0;
                    tx_idx_s   = '0;
                    tx_stop_s  = 1'b0;
                    tx_s       = 1'b0;
                    tx_busy_s  = 1'b1;
                    tx_state_s = ST_START;
                end else begin
                    tx_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tx_cnt_r == CNT_LAST) begin
                    tx_cnt_s   = '0;
                    tx_s       = tx_shift_r[0];
                    tx_state_s = ST_DATA;
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (tx_cnt_r == CNT_LAST) begin
                    tx_cnt_s = '0;
                    if (tx_idx_r == IDX_LAST) begin
                        if (PARITY_EN != 0) begin
                            tx_s       = tx_par_r;
                            tx_state_s = ST_PARITY;
                        end else begin
                            tx_s       = 1'b1;
                            tx_state_s = ST_STOP;
                        end
                    end else begin
                        tx_idx_s   = tx_idx_r + IDX_ONE;
                        tx_shift_s = {1'b0, tx_shift_r[DATA_BITS-1:1]};
                        tx_s       = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            ST_PARITY: begin
                if (tx_cnt_r == CNT_LAST) begin
                    tx_cnt_s   = '0;
                    tx_s       = 1'b1;
                    tx_state_s = ST_STOP;
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (tx_cnt_r == CNT_LAST) begin
                    tx_cnt_s = '0;
                    if (tx_stop_r == STOP_LAST) begin
                        tx_s       = 1'b1;
                        tx_busy_s  = 1'b0;
                        tx_done_s  = 1'b1;
                        tx_state_s = ST_IDLE;
                    end else begin
                        tx_stop_s = 1'b1;
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                tx_s       = 1'b1;
                tx_busy_s  = 1'b0;
                tx_state_s = ST_IDLE;
            end
        endcase
    end

    // TX state and output registers
    always_ff @(posedge clk_in) begin
        if (rst) begin
            tx_state_r <= ST_IDLE;
            tx_cnt_r   <= '0;
            tx_idx_r   <= '0;
            tx_stop_r  <= 1'b0;
            tx_shift_r <= '0;
            tx_par_r   <= 1'b0;
            tx_r       <= 1'b1;
            tx_busy_r  <= 1'b0;
            tx_done_r  <= 1'b0;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_idx_r   <= tx_idx_s;
            tx_stop_r  <= tx_stop_s;
            tx_shift_r <= tx_shift_s;
            tx_par_r   <= tx_par_s;
            tx_r       <= tx_s;
            tx_busy_r  <= tx_busy_s;
            tx_done_r  <= tx_done_s;
        end
    end

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clk_in) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // RX next-state: START re-checks at half a bit, then samples every full bit
    always_comb begin
        rx_state_s    = rx_state_r;
        rx_cnt_s      = rx_cnt_r;
        rx_idx_s      = rx_idx_r;
        rx_shift_s    = rx_shift_r;
        rx_perr_s     = rx_perr_r;
        rx_dout_s     = rx_dout_r;
        rx_valid_s    = 1'b0;
        rx_perr_out_s = rx_perr_out_r;
        rx_ferr_s     = rx_ferr_r;
        case (rx_state_r)
            ST_IDLE: begin
                if (rx_prev_r && !rx_sync_r) begin
                    rx_cnt_s   = '0;
                    rx_state_s = ST_START;
                end else begin
                    rx_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (rx_cnt_r == CNT_HALF) begin
                    rx_cnt_s  = '0;
                    rx_idx_s  = '0;
                    rx_perr_s = 1'b0;
                    if (rx_sync_r) begin
                        rx_state_s = ST_IDLE;
                    end else begin
                        rx_state_s = ST_DATA;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (rx_cnt_r == CNT_LAST) begin
                    rx_cnt_s   = '0;
                    rx_shift_s = {rx_sync_r, rx_shift_r[DATA_BITS-1:1]};
                    if (rx_idx_r == IDX_LAST) begin
                        if (PARITY_EN != 0) begin
                            rx_state_s = ST_PARITY;
                        end else begin
                            rx_state_s = ST_STOP;
                        end
                    end else begin
                        rx_idx_s = rx_idx_r + IDX_ONE;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            ST_PARITY: begin
                if (rx_cnt_r == CNT_LAST) begin
                    rx_cnt_s   = '0;
                    rx_perr_s  = rx_sync_r ^ parity_of(rx_shift_r);
                    rx_state_s = ST_STOP;
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                // Returning to IDLE at mid-stop re-arms the receiver half a bit early
                if (rx_cnt_r == CNT_LAST) begin
                    rx_cnt_s      = '0;
                    rx_dout_s     = rx_shift_r;
                    rx_perr_out_s = (PARITY_EN != 0) && rx_perr_r;
                    rx_ferr_s     = !rx_sync_r;
                    rx_valid_s    = 1'b1;
                    rx_state_s    = ST_IDLE;
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                rx_cnt_s   = '0;
                rx_state_s = ST_IDLE;
            end
        endcase
    end

    // RX state and output registers
    always_ff @(posedge clk_in) begin
        if (rst) begin
            rx_state_r    <= ST_IDLE;
            rx_cnt_r      <= '0;
            rx_idx_r      <= '0;
            rx_shift_r    <= '0;
            rx_perr_r     <= 1'b0;
            rx_dout_r     <= '0;
            rx_valid_r    <= 1'b0;
            rx_perr_out_r <= 1'b0;
            rx_ferr_r     <= 1'b0;
        end else begin
            rx_state_r    <= rx_state_s;
            rx_cnt_r      <= rx_cnt_s;
            rx_idx_r      <= rx_idx_s;
            rx_shift_r    <= rx_shift_s;
            rx_perr_r     <= rx_perr_s;
            rx_dout_r     <= rx_dout_s;
            rx_valid_r    <= rx_valid_s;
            rx_perr_out_r <= rx_perr_out_s;
            rx_ferr_r     <= rx_ferr_s;
        end
    end

endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: an 8E1 instance at 4 clocks/bit and a 7O2 instance at 16 clocks/bit,
// with received frames collected by a monitor and checked against a queue of expected results.
module tb_uart_core_param;
    localparam int CPB = 4;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic       rst;
    logic       tx_start, tx, tx_busy, tx_done;
    logic [7:0] tx_din;
    logic       rx_line, rx_force, loop_en;
    logic [7:0] rx_dout;
    logic       rx_valid, rx_parity_err, rx_frame_err;

    logic       tx_start2, tx2, tx_busy2, tx_done2;
    logic [6:0] tx_din2;
    logic [6:0] rx_dout2;
    logic       rx_valid2, rx_parity_err2, rx_frame_err2;

    assign rx_line = loop_en ? tx : rx_force;

    uart_core_param #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) dut (
        .clk_in(clk_in), .rst(rst), .tx_start(tx_start), .tx_din(tx_din), .tx_busy(tx_busy),
        .tx_done(tx_done), .tx(tx), .rx(rx_line), .rx_dout(rx_dout), .rx_valid(rx_valid),
        .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err));

    uart_core_param #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2), .CLKS_PER_BIT(16)) dut_cfg (
        .clk_in(clk_in), .rst(rst), .tx_start(tx_start2), .tx_din(tx_din2), .tx_busy(tx_busy2),
        .tx_done(tx_done2), .tx(tx2), .rx(tx2), .rx_dout(rx_dout2), .rx_valid(rx_valid2),
        .rx_parity_err(rx_parity_err2), .rx_frame_err(rx_frame_err2));

    int pass_cnt  = 0;
    int total_cnt = 0;
    int done_cnt  = 0;
    logic [9:0] exp_q[$], obs_q[$];
    logic [8:0] exp2_q[$], obs2_q[$];

    // Monitor: every rx_valid pulse becomes an observed scoreboard entry
    always @(negedge clk_in) begin
        if (rx_valid === 1'b1) obs_q.push_back({rx_dout, rx_parity_err, rx_frame_err});
        if (rx_valid2 === 1'b1) obs2_q.push_back({rx_dout2, rx_parity_err2, rx_frame_err2});
        if (tx_done === 1'b1) done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic drive_rx_frame(input logic [7:0] d, input logic par, input logic stop);
        rx_force = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_force = d[i];
            tick(CPB);
        end
        rx_force = par;
        tick(CPB);
        rx_force = stop;
        tick(CPB);
    endtask

    task automatic test_reset();
        int d0;
        rst = 1'b1; tx_start = 1'b0; tx_din = 8'h00; loop_en = 1'b1; rx_force = 1'b1;
        tx_start2 = 1'b0; tx_din2 = 7'h00;
        tick(3);
        total_cnt++;
        if ({tx, tx_busy, tx_done, rx_valid, rx_dout, rx_parity_err, rx_frame_err} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0})
            $display("FAIL reset_state: got tx=%b busy=%b done=%b valid=%b dout=%h perr=%b ferr=%b, expected 1 0 0 0 00 0 0",
                     tx, tx_busy, tx_done, rx_valid, rx_dout, rx_parity_err, rx_frame_err);
        else pass_cnt++;
        total_cnt++;
        if ({tx2, tx_busy2, rx_valid2} !== 3'b100) $display("FAIL reset_cfg: got %b expected 100", {tx2, tx_busy2, rx_valid2});
        else pass_cnt++;
        rst = 1'b0;
        tick(2);
        obs_q.delete();
        d0 = done_cnt;
        tx_din = 8'h96; tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        tick(12);
        rst = 1'b1;
        tick(3);
        total_cnt++;
        if ({tx, tx_busy, tx_done} !== 3'b100) $display("FAIL reset_midframe: got %b expected 100", {tx, tx_busy, tx_done});
        else pass_cnt++;
        rst = 1'b0;
        tick(60);
        total_cnt++;
        if (obs_q.size() != 0 || done_cnt != d0 || {tx, tx_busy} !== 2'b10)
            $display("FAIL reset_abandon: got valids=%0d dones=%0d tx/busy=%b expected 0 0 10", obs_q.size(), done_cnt - d0, {tx, tx_busy});
        else pass_cnt++;
    endtask

    task automatic test_tx_frame();
        logic [7:0]  d;
        logic [10:0] bits;
        logic [9:0]  got, want;
        d = 8'hA5;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        bits[9]  = ^d;
        bits[10] = 1'b1;
        obs_q.delete(); exp_q.delete();
        exp_q.push_back({d, 1'b0, 1'b0});
        loop_en = 1'b1;
        tx_din = d; tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0; tx_din = 8'h00;
        for (int c = 0; c < 44; c++) begin
            total_cnt++;
            if ({tx_busy, tx_done, tx} !== {1'b1, 1'b0, bits[c/4]})
                $display("FAIL tx_line[%0d]: got busy/done/tx=%b expected %b", c, {tx_busy, tx_done, tx}, {1'b1, 1'b0, bits[c/4]});
            else pass_cnt++;
            tick(1);
        end
        total_cnt++;
        if ({tx_busy, tx_done, tx} !== 3'b011) $display("FAIL tx_done_timing: got busy/done/tx=%b expected 011", {tx_busy, tx_done, tx});
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (tx_done !== 1'b0) $display("FAIL tx_done_width: got %b expected 0", tx_done);
        else pass_cnt++;
        for (int k = 0; k < 20 && obs_q.size() < 1; k++) tick(1);
        total_cnt++;
        if (obs_q.size() != 1) $display("FAIL loop_a5_count: got %0d expected 1", obs_q.size());
        else begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) $display("FAIL loop_a5: got %h expected %h", got, want);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic       found;
        logic [9:0] got, want;
        obs_q.delete(); exp_q.delete();
        exp_q.push_back({8'h3C, 1'b0, 1'b0});
        exp_q.push_back({8'hFF, 1'b0, 1'b0});
        loop_en = 1'b1;
        tx_din = 8'h3C; tx_start = 1'b1;
        tick(1);
        tx_din = 8'hFF;
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (tx_done === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick(1);
        end
        total_cnt++;
        if (found !== 1'b1) $display("FAIL b2b_first_done: got %b expected 1", found);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if ({tx_busy, tx} !== 2'b10) $display("FAIL b2b_no_gap: got busy/tx=%b expected 10", {tx_busy, tx});
        else pass_cnt++;
        tx_start = 1'b0;
        for (int k = 0; k < 120 && obs_q.size() < 2; k++) tick(1);
        total_cnt++;
        if (obs_q.size() != 2) $display("FAIL b2b_count: got %0d expected 2", obs_q.size());
        else pass_cnt++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            total_cnt++;
            if (got !== want) $display("FAIL b2b_data: got %h expected %h", got, want);
            else pass_cnt++;
        end
        tick(20);
        total_cnt++;
        if ({tx_busy, tx} !== 2'b01) $display("FAIL b2b_no_third: got busy/tx=%b expected 01", {tx_busy, tx});
        else pass_cnt++;
    endtask

    task automatic test_parity_err();
        logic [9:0] got, want;
        loop_en = 1'b0; rx_force = 1'b1;
        tick(8);
        obs_q.delete(); exp_q.delete();
        exp_q.push_back({8'h01, 1'b1, 1'b0});
        drive_rx_frame(8'h01, 1'b0, 1'b1);
        for (int k = 0; k < 20 && obs_q.size() < 1; k++) tick(1);
        total_cnt++;
        if (obs_q.size() != 1) $display("FAIL parity_count: got %0d expected 1", obs_q.size());
        else begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) $display("FAIL parity_err: got %h expected %h", got, want);
            else pass_cnt++;
        end
    endtask

    task automatic test_framing();
        logic [9:0] got, want;
        loop_en = 1'b0; rx_force = 1'b1;
        tick(8);
        obs_q.delete(); exp_q.delete();
        exp_q.push_back({8'h5A, 1'b0, 1'b1});
        drive_rx_frame(8'h5A, ^(8'h5A), 1'b0);
        tick(8);
        total_cnt++;
        if (obs_q.size() != 1) $display("FAIL frame_count: got %0d expected 1", obs_q.size());
        else begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) $display("FAIL frame_err: got %h expected %h", got, want);
            else pass_cnt++;
        end
        rx_force = 1'b1;
        tick(8);
        rx_force = 1'b0;
        tick(1);
        rx_force = 1'b1;
        tick(30);
        total_cnt++;
        if (obs_q.size() != 0 || rx_frame_err !== 1'b1)
            $display("FAIL false_start: got valids=%0d ferr=%b expected 0 1", obs_q.size(), rx_frame_err);
        else pass_cnt++;
        exp_q.push_back({8'hC3, 1'b0, 1'b0});
        drive_rx_frame(8'hC3, ^(8'hC3), 1'b1);
        rx_force = 1'b1;
        for (int k = 0; k < 20 && obs_q.size() < 1; k++) tick(1);
        total_cnt++;
        if (obs_q.size() != 1) $display("FAIL recover_count: got %0d expected 1", obs_q.size());
        else begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) $display("FAIL recover_frame: got %h expected %h", got, want);
            else pass_cnt++;
        end
    endtask

    task automatic test_cfg_sweep();
        logic [6:0]  d;
        logic [10:0] bits, line;
        logic [8:0]  got, want;
        int n;
        d = 7'h55;
        bits[0] = 1'b0;
        for (int i = 0; i < 7; i++) bits[i+1] = d[i];
        bits[8]  = ~(^d);
        bits[9]  = 1'b1;
        bits[10] = 1'b1;
        line = '0;
        obs2_q.delete(); exp2_q.delete();
        exp2_q.push_back({d, 1'b0, 1'b0});
        tx_din2 = d; tx_start2 = 1'b1;
        tick(1);
        tx_start2 = 1'b0;
        n = 0;
        while (tx_busy2 === 1'b1 && n < 176) begin
            if (n % 16 == 8) line[n/16] = tx2;
            tick(1);
            n++;
        end
        for (int k = 0; k < 8 && tx_busy2 === 1'b1; k++) begin
            tick(1);
            n++;
        end
        total_cnt++;
        if (n != 176 || tx_done2 !== 1'b1) $display("FAIL cfg_frame_len: got %0d cycles done=%b expected 176 1", n, tx_done2);
        else pass_cnt++;
        total_cnt++;
        if (line !== bits) $display("FAIL cfg_line: got %b expected %b", line, bits);
        else pass_cnt++;
        for (int k = 0; k < 40 && obs2_q.size() < 1; k++) tick(1);
        total_cnt++;
        if (obs2_q.size() != 1) $display("FAIL cfg_count: got %0d expected 1", obs2_q.size());
        else begin
            got = obs2_q.pop_front(); want = exp2_q.pop_front();
            if (got !== want) $display("FAIL cfg_loop: got %h expected %h", got, want);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_back_to_back();
        test_parity_err();
        test_framing();
        test_cfg_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
